// File: rtl/tlut_result_drain_pkg.sv
// Shared types and defaults for the TLUT result-side controller.
package tlut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE,
    DRAIN
  } drain_state_t;

  localparam int TLUT_DIM_MULT  = 9;
  localparam int TLUT_ACC_WIDTH = 8;

  // Lane total needs enough headroom that DIM_MULT full-scale lanes never overflow.
  function automatic int sum_width(input int dim, input int acc);
    return acc + $clog2(dim);
  endfunction

endpackage

// File: rtl/tlut_result_drain_if.sv
// Downstream result stream: one snapshot lane per beat, valid/ready handshake.
interface tlut_result_drain_if #(
  parameter int ACC_WIDTH  = 8,
  parameter int LANE_WIDTH = 4,
  parameter int SUM_WIDTH  = 12
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [LANE_WIDTH-1:0] out_lane;
  logic                  out_last;
  logic [SUM_WIDTH-1:0]  out_total;

  modport master (
    output out_valid, out_data, out_lane, out_last, out_total,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_lane, out_last, out_total,
    output out_ready
  );

endinterface

// File: rtl/tlut_result_drain_lane_sum.sv
// Combinational reduction of all cell lanes into one unsigned total.
module tlut_lane_sum #(
  parameter int DIM_MULT  = 9,
  parameter int ACC_WIDTH = 8,
  parameter int SUM_WIDTH = 12
) (
  input  logic [DIM_MULT-1:0][ACC_WIDTH-1:0] lanes_i,
  output logic [SUM_WIDTH-1:0]               sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < DIM_MULT; i++) begin
      sum_o = sum_o + SUM_WIDTH'(lanes_i[i]);
    end
  end

endmodule

// File: rtl/tlut_result_drain.sv
// Runs one accumulation window on the SIMD cell, then snapshots and streams
// every lane downstream with the lane total on the final beat.
module tlut_result_drain
  import tlut_pkg::*;
#(
  parameter int DIM_MULT      = TLUT_DIM_MULT,
  parameter int ACC_WIDTH     = TLUT_ACC_WIDTH,
  parameter int WINDOW        = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int SUM_WIDTH     = sum_width(DIM_MULT, ACC_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              cell_enable,
  input  logic [DIM_MULT-1:0][ACC_WIDTH-1:0] accumulated_mult,
  tlut_result_drain_if.master               out_if
);

  localparam int LANE_WIDTH = $clog2(DIM_MULT);
  localparam int CNT_MAX    = (WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES;
  localparam int CNT_WIDTH  = $clog2(CNT_MAX + 1);
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(DIM_MULT - 1);

  drain_state_t                       state_q, state_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [LANE_WIDTH-1:0]              lane_q, lane_d;
  logic [DIM_MULT-1:0][ACC_WIDTH-1:0] snap_q, snap_d;
  logic [SUM_WIDTH-1:0]               total_q, total_d;
  logic [SUM_WIDTH-1:0]               lane_sum;

  tlut_lane_sum #(
    .DIM_MULT  (DIM_MULT),
    .ACC_WIDTH (ACC_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_lane_sum (
    .lanes_i (accumulated_mult),
    .sum_o   (lane_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    snap_d  = snap_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_WIDTH'(WINDOW - 1);
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_WIDTH'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          snap_d  = accumulated_mult;
          total_d = lane_sum;
          lane_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Snapshot stays frozen here; only the lane pointer advances on acceptance.
        if (out_if.out_ready) begin
          if (lane_q == LAST_LANE) begin
            state_d = IDLE;
          end else begin
            lane_d = lane_q + LANE_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      snap_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      snap_q  <= snap_d;
      total_q <= total_d;
    end
  end

  // Outputs decode registered state only, so they hold steady during a stall.
  assign busy             = (state_q != IDLE);
  assign cell_enable      = (state_q == RUN);
  assign out_if.out_valid = (state_q == DRAIN);
  assign out_if.out_last  = out_if.out_valid && (lane_q == LAST_LANE);
  assign out_if.out_lane  = out_if.out_valid ? lane_q : '0;
  assign out_if.out_data  = out_if.out_valid ? snap_q[lane_q] : '0;
  assign out_if.out_total = out_if.out_last ? total_q : '0;

endmodule

// File: doc/tlut_result_drain.md
# tlut_result_drain

Result-side controller for the TLUT SIMD cell.
- Opens a fixed-length accumulation window by driving the cell's `enable`, then waits for the cell's output to settle.
- Snapshots all `DIM_MULT` lanes of `accumulated_mult` and streams them out one lane per beat over a valid/ready handshake.
- Presents the total of all lanes alongside the final beat.
- Sits between `simd_cell` and the downstream result buffer; it is the consumer end of the interface that the operand driver feeds.

## Interface

Parameters:
- `DIM_MULT`, 9: number of product lanes.
- `ACC_WIDTH`, 8: width of each lane.
- `WINDOW`, 16: cycles `cell_enable` is held high per job; must be ≥1.
- `SETTLE_CYCLES`, 2: cycles waited after the window before the snapshot; must be ≥1.
- `SUM_WIDTH`, `ACC_WIDTH+$clog2(DIM_MULT)` (12): width of the lane total.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: sole clock, rising edge.
  - `rst` input 1: synchronous, active-high reset.
- Job control:
  - `start` input 1: job request; sampled only in IDLE.
  - `busy` output 1: high in every state except IDLE.
- Cell side:
  - `cell_enable` output 1: drives `simd_cell.enable`.
  - `accumulated_mult` input `[DIM_MULT-1:0][ACC_WIDTH-1:0]`: cell lanes.
- Downstream stream:
  - `out_valid` output 1: a beat is presented.
  - `out_ready` input 1: downstream accepts the beat.
  - `out_data` output `ACC_WIDTH`: lane value.
  - `out_lane` output `$clog2(DIM_MULT)`: index of the lane presented.
  - `out_last` output 1: high on lane `DIM_MULT-1`.
  - `out_total` output `SUM_WIDTH`: sum of all snapshot lanes; valid only when `out_last` is high, zero otherwise.

## Operation

States:
- IDLE: outputs low. `start`=1 moves to RUN and loads the counter with `WINDOW-1`.
- RUN: `cell_enable`=1. The counter decrements each cycle. At 0, move to SETTLE and load the counter with `SETTLE_CYCLES-1`.
- SETTLE: `cell_enable`=0. The counter decrements each cycle. At 0:
  - register all lanes of `accumulated_mult` into the snapshot;
  - register their zero-extended sum into `total`;
  - clear the lane index;
  - move to DRAIN.
- DRAIN: `out_valid`=1 and presents snapshot lane `out_lane`.
  - On `out_valid && out_ready`, increment the lane index.
  - If the accepted beat has `out_last` set, go to IDLE instead.

Rules:
- `start` outside IDLE is ignored; no queuing.
- The snapshot is frozen from entry to DRAIN until return to IDLE. Changes on `accumulated_mult` during DRAIN are not observed.
- Lane order is ascending: lane 0 is the least-significant slice `accumulated_mult[0]`.
- Sum arithmetic is unsigned and cannot overflow: 9×255 = 2295 < 4096.
- While `out_valid` is high and `out_ready` is low, `out_data`, `out_lane`, `out_last` and `out_total` must hold stable.
- Reset at any point, including mid-RUN and mid-DRAIN, returns to IDLE in the next cycle. No partial stream is resumed.

## Timing

- Reset values: `busy`=0, `cell_enable`=0, `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `out_total`=0. Snapshot and counter are cleared.
- All outputs are registered.
- Cycle numbering: `start` is sampled high at edge k.
  - `cell_enable`=1 in cycles k+1 … k+`WINDOW`.
  - SETTLE occupies the next `SETTLE_CYCLES` cycles.
  - The first `out_valid` appears in cycle k+`WINDOW`+`SETTLE_CYCLES`+1.
  - With defaults, `start` at edge 0 gives enable in cycles 1–16, SETTLE in cycles 17–18, first beat in cycle 19.
- With `out_ready` tied high, DRAIN lasts exactly `DIM_MULT` cycles, one beat per cycle.
- `busy` rises the cycle after `start` is accepted. It falls the cycle after the last beat is accepted.
- A `start` pulse in that final cycle (`busy` still high) is ignored. A new `start` is accepted no earlier than the first IDLE cycle.

## Structure

- Package `tlut_pkg` holds:
  - state enum `drain_state_t` (IDLE, RUN, SETTLE, DRAIN);
  - defaults `TLUT_DIM_MULT=9` and `TLUT_ACC_WIDTH=8`;
  - function `sum_width(dim, acc)`.
- Sub-module: `tlut_lane_sum`, a combinational adder tree reducing `DIM_MULT` lanes to `SUM_WIDTH`. Its result is registered inside `tlut_result_drain` at the snapshot edge.
- The FSM, down-counter, snapshot register and output mux are inline.

## Test plan

1. Reset, then idle 5 cycles → every output is 0 and `cell_enable` never rises.
2. Bench drives lane i = 3·i. One `start` pulse, `out_ready`=1 →
   - `cell_enable` high for exactly 16 cycles;
   - first `out_valid` 19 cycles after `start`;
   - beats 0,3,…,24 with `out_lane` 0…8;
   - `out_last` and `out_total`=108 on beat 8;
   - `busy` low on the following cycle.
3. Backpressure: `out_ready` toggles 1,0,0,1,… → no beat is lost or duplicated, held data is stable while stalled, and order is unchanged.
4. Snapshot freeze: after DRAIN entry, change all lanes to 255 → the streamed values remain 3·i and total remains 108.
5. `start` asserted continuously → exactly one job per IDLE visit; a `start` in the last-beat cycle is ignored.
6. `rst` asserted during RUN (cycle 8) and during DRAIN (beat 4) → IDLE next cycle with all outputs 0. A following `start` produces a complete 9-beat stream beginning at lane 0.
